// File: rtl/wash_cycle_sched_pkg.sv
// Shared types and defaults for the multi-pass wash program sequencer.
package wash_pkg;

    localparam int unsigned WASH_CYC_DEF   = 8;
    localparam int unsigned SPIN_CYC_DEF   = 4;
    localparam int unsigned LAUNCH_TMO_DEF = 16;
    localparam int unsigned TMR_W_DEF      = 8;
    localparam int unsigned PASS_W         = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ABORT  = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    // Phase timers only count while a pass is being launched or run.
    function automatic logic phase_active(state_e s);
        return (s == ST_LAUNCH) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/wash_cycle_sched_if.sv
// Control/status bundle between the program sequencer, the user side and wash_fsm.
interface wash_cycle_sched_if;
    import wash_pkg::*;

    logic              go;
    logic [PASS_W-1:0] prog;
    logic              abort;
    logic              fsm_ready;
    logic              fsm_water_in;
    logic              fsm_wash;
    logic              fsm_speed;
    logic              fsm_start;
    logic              fsm_rst;
    logic              wash_tmo;
    logic              spin_tmo;
    logic              soap;
    logic              busy;
    logic              done;
    logic              fault;
    logic [PASS_W-1:0] pass_cnt;

    modport slave (
        input  go, prog, abort, fsm_ready, fsm_water_in, fsm_wash, fsm_speed,
        output fsm_start, fsm_rst, wash_tmo, spin_tmo, soap, busy, done, fault, pass_cnt
    );

    modport master (
        output go, prog, abort, fsm_ready, fsm_water_in, fsm_wash, fsm_speed,
        input  fsm_start, fsm_rst, wash_tmo, spin_tmo, soap, busy, done, fault, pass_cnt
    );

endinterface

// File: rtl/wash_cycle_sched_timer.sv
// Saturating phase timer: one tmo pulse on the N-th consecutive cycle of run.
module wash_phase_timer #(
    parameter int unsigned N     = 8,
    parameter int unsigned TMR_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic run,
    output logic tmo
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    // Saturating at N keeps a long phase from producing a second pulse.
    always_comb begin
        cnt_d = '0;
        tmo_d = 1'b0;
        if (en && run && !clr) begin
            cnt_d = (cnt_q == TMR_W'(N)) ? cnt_q : cnt_q + TMR_W'(1);
            tmo_d = (cnt_q == TMR_W'(N - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;

endmodule

// File: rtl/wash_cycle_sched.sv
// Multi-pass program sequencer driving wash_fsm start and its phase expiry pulses.
module wash_cycle_sched
    import wash_pkg::*;
#(
    parameter int unsigned WASH_CYC   = WASH_CYC_DEF,
    parameter int unsigned SPIN_CYC   = SPIN_CYC_DEF,
    parameter int unsigned LAUNCH_TMO = LAUNCH_TMO_DEF,
    parameter int unsigned TMR_W      = TMR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    wash_cycle_sched_if.slave  bus
);

    localparam int unsigned LAUNCH_W = $clog2(LAUNCH_TMO + 1);

    state_e              state_q, state_d;
    logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [PASS_W-1:0]   pass_last_q, pass_last_d;
    logic [LAUNCH_W-1:0] launch_cnt_q, launch_cnt_d;
    logic                ready_q;

    logic fsm_start_q, fsm_start_d;
    logic fsm_rst_q, fsm_rst_d;
    logic soap_q, soap_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic fault_q, fault_d;
    logic timer_en;
    logic wash_tmo, spin_tmo;

    // Next state; abort overrides every other event in the same cycle.
    always_comb begin
        state_d      = state_q;
        pass_cnt_d   = pass_cnt_q;
        pass_last_d  = pass_last_q;
        launch_cnt_d = '0;

        if (bus.abort) begin
            state_d = ST_ABORT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.go && bus.fsm_ready) begin
                        state_d     = ST_LAUNCH;
                        pass_last_d = bus.prog;
                        pass_cnt_d  = '0;
                    end
                end
                ST_LAUNCH: begin
                    if (!bus.fsm_ready) begin
                        state_d = ST_RUN;
                    end else if (launch_cnt_q == LAUNCH_W'(LAUNCH_TMO - 1)) begin
                        state_d = ST_FAULT;
                    end else begin
                        launch_cnt_d = launch_cnt_q + LAUNCH_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.fsm_ready && !ready_q) begin
                        if (pass_cnt_q == pass_last_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d    = ST_LAUNCH;
                            pass_cnt_d = pass_cnt_q + PASS_W'(1);
                        end
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                ST_ABORT: state_d = ST_IDLE;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they follow their cause by one edge.
        fsm_start_d = (state_d == ST_LAUNCH);
        busy_d      = phase_active(state_d);
        done_d      = (state_d == ST_DONE);
        fault_d     = (state_d == ST_FAULT);
        fsm_rst_d   = (state_d == ST_ABORT) || ((state_d == ST_FAULT) && (state_q != ST_FAULT));
        soap_d      = bus.fsm_water_in && (state_d == ST_RUN) && (pass_cnt_d == '0);
    end

    assign timer_en = phase_active(state_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pass_cnt_q   <= '0;
            pass_last_q  <= '0;
            launch_cnt_q <= '0;
            ready_q      <= 1'b0;
            fsm_start_q  <= 1'b0;
            fsm_rst_q    <= 1'b0;
            soap_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pass_cnt_q   <= pass_cnt_d;
            pass_last_q  <= pass_last_d;
            launch_cnt_q <= launch_cnt_d;
            ready_q      <= bus.fsm_ready;
            fsm_start_q  <= fsm_start_d;
            fsm_rst_q    <= fsm_rst_d;
            soap_q       <= soap_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
        end
    end

    wash_phase_timer #(.N(WASH_CYC), .TMR_W(TMR_W)) u_wash_tmr (
        .clk   (clk),
        .reset (reset),
        .en    (timer_en),
        .clr   (bus.abort),
        .run   (bus.fsm_wash),
        .tmo   (wash_tmo)
    );

    wash_phase_timer #(.N(SPIN_CYC), .TMR_W(TMR_W)) u_spin_tmr (
        .clk   (clk),
        .reset (reset),
        .en    (timer_en),
        .clr   (bus.abort),
        .run   (bus.fsm_speed),
        .tmo   (spin_tmo)
    );

    assign bus.fsm_start = fsm_start_q;
    assign bus.fsm_rst   = fsm_rst_q;
    assign bus.wash_tmo  = wash_tmo;
    assign bus.spin_tmo  = spin_tmo;
    assign bus.soap      = soap_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_wash_cycle_sched.sv
// Directed plus randomized bench for wash_cycle_sched with a scripted wash_fsm and event scoreboard.
module tb_wash_cycle_sched;

    localparam int unsigned WASH_CYC   = 8;
    localparam int unsigned SPIN_CYC   = 4;
    localparam int unsigned LAUNCH_TMO = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    wash_cycle_sched_if bus ();

    wash_cycle_sched #(
        .WASH_CYC   (WASH_CYC),
        .SPIN_CYC   (SPIN_CYC),
        .LAUNCH_TMO (LAUNCH_TMO),
        .TMR_W      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the falling edge.
    int   n_done = 0, n_wtmo = 0, n_stmo = 0, n_rst = 0, n_launch = 0, n_soap = 0;
    logic start_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.done)     n_done++;
        if (bus.wash_tmo) n_wtmo++;
        if (bus.spin_tmo) n_stmo++;
        if (bus.fsm_rst)  n_rst++;
        if (bus.soap)     n_soap++;
        if (bus.fsm_start && !start_prev) n_launch++;
        start_prev = bus.fsm_start;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tmo(input bit spin, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(spin ? bus.spin_tmo : bus.wash_tmo) && n < 40);
    endtask

    function automatic logic [31:0] all_outs();
        return {22'd0, bus.fsm_start, bus.fsm_rst, bus.wash_tmo, bus.spin_tmo,
                bus.soap, bus.busy, bus.done, bus.fault, bus.pass_cnt};
    endfunction

    // One pass as seen by wash_fsm; entered just after fsm_start has risen.
    task automatic run_pass(input int p, input int last, input int dly, input int wl, input int dr);
        int n;
        chk("launch_start", bus.fsm_start, 1);
        chk("launch_pass", bus.pass_cnt, p);
        chk("launch_busy", bus.busy, 1);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("start_hold", bus.fsm_start, 1);
        end
        bus.fsm_ready = 1'b0;
        tick();
        chk("start_drop", bus.fsm_start, 0);
        bus.fsm_water_in = 1'b1;
        for (int i = 0; i < wl; i++) begin
            tick();
            chk("soap", bus.soap, (p == 0) ? 1 : 0);
        end
        bus.fsm_water_in = 1'b0;
        tick();
        chk("soap_off", bus.soap, 0);
        bus.fsm_wash = 1'b1;
        wait_tmo(1'b0, n);
        chk("wash_lat", n, WASH_CYC);
        bus.fsm_wash = 1'b0;
        tick();
        chk("wash_pulse", bus.wash_tmo, 0);
        repeat (dr) tick();
        bus.fsm_speed = 1'b1;
        wait_tmo(1'b1, n);
        chk("spin_lat", n, SPIN_CYC);
        bus.fsm_speed = 1'b0;
        tick();
        chk("spin_pulse", bus.spin_tmo, 0);
        bus.fsm_ready = 1'b1;
        tick();
        if (p == last) begin
            chk("done_pulse", bus.done, 1);
            chk("done_busy", bus.busy, 0);
            chk("done_pass", bus.pass_cnt, last);
            tick();
            chk("done_once", bus.done, 0);
            chk("done_hold_pass", bus.pass_cnt, last);
        end
    endtask

    // Whole program; expected totals follow directly from the pass count.
    task automatic run_prog(input int pr, input bit rand_timing);
        int l0, d0, w0, s0, st0, exp_soap;
        int dly, wl, dr;
        l0 = n_launch; d0 = n_done; w0 = n_wtmo; s0 = n_soap; st0 = n_stmo;
        exp_soap = 0;
        bus.prog = 2'(pr);
        bus.go   = 1'b1;
        tick();
        bus.go   = 1'b0;
        bus.prog = 2'($urandom);
        for (int p = 0; p <= pr; p++) begin
            dly = rand_timing ? int'($urandom_range(4, 0)) : 0;
            wl  = rand_timing ? int'($urandom_range(5, 1)) : 3;
            dr  = rand_timing ? int'($urandom_range(3, 0)) : 1;
            if (p == 0) exp_soap += wl;
            run_pass(p, pr, dly, wl, dr);
        end
        chk("prog_launches", n_launch - l0, pr + 1);
        chk("prog_done_cnt", n_done - d0, 1);
        chk("prog_wash_tmo", n_wtmo - w0, pr + 1);
        chk("prog_spin_tmo", n_stmo - st0, pr + 1);
        chk("prog_soap_cyc", n_soap - s0, exp_soap);
    endtask

    initial begin
        int w0, d0, r0, n;
        reset            = 1'b1;
        bus.go           = 1'b0;
        bus.prog         = '0;
        bus.abort        = 1'b0;
        bus.fsm_ready    = 1'b1;
        bus.fsm_water_in = 1'b0;
        bus.fsm_wash     = 1'b0;
        bus.fsm_speed    = 1'b0;
        repeat (3) tick();
        chk("reset_outs", all_outs(), 0);
        reset = 1'b0;
        tick();
        chk("idle_outs", all_outs(), 0);

        // Single pass and four passes with fixed timing.
        run_prog(0, 1'b0);
        run_prog(3, 1'b0);

        // Randomized programs.
        for (int k = 0; k < 6; k++) run_prog(int'($urandom_range(3, 0)), 1'b1);

        // Abort mid-wash with the wash timer at 5.
        bus.prog = 2'd2;
        bus.go   = 1'b1;
        tick();
        bus.go        = 1'b0;
        bus.fsm_ready = 1'b0;
        tick();
        bus.fsm_wash = 1'b1;
        repeat (5) tick();
        w0 = n_wtmo; d0 = n_done;
        bus.abort = 1'b1;
        tick();
        chk("abort_rst", bus.fsm_rst, 1);
        chk("abort_start", bus.fsm_start, 0);
        chk("abort_busy", bus.busy, 0);
        bus.abort     = 1'b0;
        bus.fsm_ready = 1'b1;
        tick();
        chk("abort_rst_once", bus.fsm_rst, 0);
        repeat (6) tick();
        bus.fsm_wash = 1'b0;
        chk("abort_no_tmo", n_wtmo - w0, 0);
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_idle_busy", bus.busy, 0);
        bus.prog = 2'd0;
        bus.go   = 1'b1;
        tick();
        bus.go = 1'b0;
        run_pass(0, 0, 1, 2, 1);

        // Launch fault with fsm_ready stuck high.
        r0 = n_rst;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        for (int i = 1; i < int'(LAUNCH_TMO); i++) begin
            tick();
            chk("fault_early", bus.fault, 0);
        end
        tick();
        chk("fault_set", bus.fault, 1);
        chk("fault_rst", bus.fsm_rst, 1);
        chk("fault_busy", bus.busy, 0);
        chk("fault_start", bus.fsm_start, 0);
        tick();
        chk("fault_sticky", bus.fault, 1);
        chk("fault_rst_once", n_rst - r0, 1);
        bus.go = 1'b1;
        repeat (2) tick();
        bus.go = 1'b0;
        chk("fault_go_ignored", bus.fsm_start, 0);
        chk("fault_still", bus.fault, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("fault_clear", bus.fault, 0);
        chk("fault_abort_rst", bus.fsm_rst, 1);
        tick();
        chk("fault_idle_outs", all_outs(), 0);

        // go and abort together in IDLE.
        bus.go    = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.go    = 1'b0;
        bus.abort = 1'b0;
        chk("goabort_rst", bus.fsm_rst, 1);
        chk("goabort_start", bus.fsm_start, 0);
        tick();
        chk("goabort_idle", bus.fsm_start | bus.busy | bus.fsm_rst, 0);

        // Wash held 20 cycles gives exactly one pulse.
        bus.prog = 2'd0;
        bus.go   = 1'b1;
        tick();
        bus.go        = 1'b0;
        bus.fsm_ready = 1'b0;
        tick();
        w0 = n_wtmo;
        bus.fsm_wash = 1'b1;
        repeat (20) tick();
        bus.fsm_wash = 1'b0;
        tick();
        chk("wash_long_once", n_wtmo - w0, 1);
        bus.fsm_speed = 1'b1;
        wait_tmo(1'b1, n);
        chk("spin_lat_long", n, SPIN_CYC);
        bus.fsm_speed = 1'b0;
        bus.fsm_ready = 1'b1;
        tick();
        chk("long_done", bus.done, 1);
        tick();

        // Reset during the second pass.
        bus.prog = 2'd1;
        bus.go   = 1'b1;
        tick();
        bus.go = 1'b0;
        run_pass(0, 1, 0, 1, 0);
        bus.fsm_ready = 1'b0;
        tick();
        bus.fsm_water_in = 1'b1;
        repeat (2) tick();
        chk("pre_reset_pass", bus.pass_cnt, 1);
        chk("pre_reset_busy", bus.busy, 1);
        reset = 1'b1;
        tick();
        chk("midrun_reset_outs", all_outs(), 0);
        reset            = 1'b0;
        bus.fsm_water_in = 1'b0;
        bus.fsm_ready    = 1'b1;
        tick();
        chk("post_reset_outs", all_outs(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_cycle_sched.md
Name: wash_cycle_sched

Overview:
- Multi-pass program sequencer that sits above wash_fsm and drives its start input.
- Runs a selected number of passes: one main wash plus 0-3 rinses.
- Generates the timed-phase expiry pulses, wash_tmo (Wash->Drain) and spin_tmo (Speed->Ready), that wash_fsm consumes.
- Provides abort and fault handling so the top level only issues go/abort.

Parameters:
- WASH_CYC, 8, clock cycles of continuous fsm_wash before wash_tmo (160 ns at 50 MHz).
- SPIN_CYC, 4, clock cycles of continuous fsm_speed before spin_tmo (80 ns).
- LAUNCH_TMO, 16, cycles fsm_start may be held with fsm_ready still high before fault.
- TMR_W, 8, phase timer width; must hold max(WASH_CYC, SPIN_CYC).

Ports:
- clk  in  1  system clock, 50 MHz, rising edge.
- reset  in  1  synchronous, active-high reset.
- go  in  1  user start request; level-sampled, acted on only in IDLE.
- prog  in  2  pass count minus 1 (0 = main only, 3 = main + 3 rinses); latched on accepted go.
- abort  in  1  cancel the program; highest priority.
- fsm_ready  in  1  wash_fsm ready output.
- fsm_water_in  in  1  wash_fsm water_in output.
- fsm_wash  in  1  wash_fsm wash output.
- fsm_speed  in  1  wash_fsm speed output.
- fsm_start  out  1  to wash_fsm start.
- fsm_rst  out  1  one-cycle reset pulse to wash_fsm on abort/fault.
- wash_tmo  out  1  one-cycle pulse, wash phase expired.
- spin_tmo  out  1  one-cycle pulse, spin phase expired.
- soap  out  1  detergent valve.
- busy  out  1  program in progress.
- done  out  1  one-cycle pulse, program completed.
- fault  out  1  sticky, FSM failed to accept start.
- pass_cnt  out  2  index of current pass, 0-based.

Behaviour:
- Reset: all outputs 0; state IDLE; timers 0; latched pass total 0.
- All outputs are registered, so each one changes on the clk edge after its cause.
- States: IDLE, LAUNCH, RUN, DONE, ABORT, FAULT.
- IDLE:
  - busy=0.
  - go=1 and fsm_ready=1: latch total=prog+1, pass_cnt=0, go to LAUNCH.
  - go while fsm_ready=0 is ignored.
- LAUNCH:
  - busy=1, fsm_start=1.
  - Stay until fsm_ready=0 is sampled, then go to RUN; fsm_start drops the next cycle.
  - Launch counter reaches LAUNCH_TMO with fsm_ready still 1: go to FAULT.
- RUN:
  - fsm_start=0.
  - On a rising fsm_ready (0 last cycle, 1 now): if pass_cnt==total-1, go to DONE; else pass_cnt+1 and go to LAUNCH.
- DONE: done=1 for exactly one cycle; busy=0; go to IDLE; pass_cnt holds its final value until the next accepted go.
- ABORT (entered from any state on abort=1, including IDLE):
  - fsm_rst=1 for one cycle; fsm_start=0 immediately; no done pulse.
  - Timers clear; go to IDLE.
  - abort beats go, ready edges and timer expiry in the same cycle.
- FAULT:
  - fault=1 and fsm_rst=1 for one cycle on entry; busy=0.
  - Stay until reset, or abort (abort clears fault and goes to IDLE).
- Phase timers:
  - Wash timer increments each cycle fsm_wash=1 and clears to 0 whenever fsm_wash=0.
  - wash_tmo=1 for one cycle on the WASH_CYC-th consecutive cycle with fsm_wash high.
  - The counter then saturates: no repeat pulse while fsm_wash stays high.
  - Spin timer behaves identically on fsm_speed with SPIN_CYC.
  - Timers run only in LAUNCH/RUN; forced to 0 in all other states.
- soap = fsm_water_in and state RUN and pass_cnt==0; rinse passes get no soap.
- prog changes while busy have no effect.

Decomposition:
- Package wash_pkg holds:
  - state encoding constants (IDLE..FAULT);
  - default WASH_CYC/SPIN_CYC/LAUNCH_TMO;
  - PASS_W=2.
- Sub-module wash_phase_timer (params N, TMR_W; ports clk, reset, en, clr, run, tmo) is instantiated twice, once for wash and once for spin.

Test Plan:
- Single pass: prog=0, go=1 with fsm_ready=1, fsm model answering.
  - fsm_start high from the cycle after go until fsm_ready falls.
  - wash_tmo exactly 8 cycles after fsm_wash rises.
  - spin_tmo exactly 4 cycles after fsm_speed rises.
  - done pulses once; pass_cnt=0.
- Four passes: prog=3.
  - Four launches with pass_cnt 0,1,2,3.
  - soap only during water_in of pass 0.
  - One done after the 4th ready edge; busy low in the same cycle.
- Abort mid-wash: abort=1 while fsm_wash=1 and timer at 5.
  - fsm_rst one cycle, no wash_tmo, no done; IDLE on the next cycle.
  - A following go is accepted.
- Launch fault: fsm_ready held at 1 after go.
  - fault set on cycle 16 of LAUNCH; fsm_rst pulses once.
  - go ignored while faulted; abort clears fault.
- Simultaneous events: go+abort in IDLE -> stays IDLE with an fsm_rst pulse.
  - fsm_wash held 20 cycles -> exactly one wash_tmo.
  - reset asserted mid-RUN -> all outputs 0 on the next edge.
